// File: rtl/lsb_mem_exec_pkg.sv
// lsb_mem_exec_pkg: shared definitions for the LSB memory execution stage.
// Holds the RV32I load/store funct3 codes, the FSM state encoding and the
// byte-count helper used when an operation is accepted.
package lsb_mem_exec_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_COMMIT,
        ST_STORE,
        ST_DONE
    } state_t;

    // Index of the last byte of the access: 1, 2 or 4 bytes. The unused
    // size code 11 falls into the word case.
    function automatic logic [1:0] last_byte_idx(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/lsb_mem_exec_load_extend.sv
// lsb_mem_exec_load_extend: combinational load-value extension.
// Ports:
//   i_funct3 - RV32I load funct3
//   i_raw    - little-endian assembled raw bytes (unused upper bytes are 0)
//   o_value  - sign/zero-extended result; unknown codes pass i_raw through
module lsb_mem_exec_load_extend
    import lsb_mem_exec_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_raw,
    output logic [31:0] o_value
);

    always_comb begin
        o_value = i_raw;
        case (i_funct3)
            F3_LB:   o_value = {{24{i_raw[7]}}, i_raw[7:0]};
            F3_LH:   o_value = {{16{i_raw[15]}}, i_raw[15:0]};
            F3_LBU:  o_value = {24'h0, i_raw[7:0]};
            F3_LHU:  o_value = {16'h0, i_raw[15:0]};
            default: o_value = i_raw;
        endcase
    end

endmodule

// File: rtl/lsb_mem_exec.sv
// lsb_mem_exec: executes one load/store at a time from the load/store buffer,
// byte-serially over the shared memory-controller port.
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (low freezes everything)
//   issue_*        - operation handshake from the LSB (issue_ready only in IDLE)
//   roll_back      - flush; ignored once a store is committed
//   commit_*       - ROB store commit
//   mem_*          - byte request / ack port to the memory controller
//   lsb_bc_*       - load result broadcast (one-cycle pulse)
//   store_done*    - pulse when the last store byte is acked
module lsb_mem_exec
    import lsb_mem_exec_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int ENTRY_BITS = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic                  issue_is_store,
    input  logic [2:0]            issue_funct3,
    input  logic [ADDR_W-1:0]     issue_base,
    input  logic [ADDR_W-1:0]     issue_data,
    input  logic [ADDR_W-1:0]     issue_imm,
    input  logic [ENTRY_BITS-1:0] issue_entry,
    input  logic                  roll_back,
    input  logic                  commit_store,
    input  logic [ENTRY_BITS-1:0] commit_entry,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic                  lsb_bc_valid,
    output logic [ENTRY_BITS-1:0] lsb_bc_entry,
    output logic [ADDR_W-1:0]     lsb_bc_value,
    output logic                  store_done,
    output logic [ENTRY_BITS-1:0] store_done_entry
);

    state_t                r_state;
    logic [2:0]            r_funct3;
    logic [ADDR_W-1:0]     r_addr;
    logic [ADDR_W-1:0]     r_data;
    logic [ADDR_W-1:0]     r_raw;
    logic [ENTRY_BITS-1:0] r_entry;
    logic [1:0]            r_k;
    logic [1:0]            r_last;
    logic                  r_mem_req;
    logic                  r_mem_wr;
    logic                  r_store_done;

    logic                  w_last_ack;
    logic [ADDR_W-1:0]     w_ext;

    assign w_last_ack = mem_ack && (r_k == r_last);

    lsb_mem_exec_load_extend u_ext (
        .i_funct3 (r_funct3),
        .i_raw    (r_raw),
        .o_value  (w_ext)
    );

    assign issue_ready      = (r_state == ST_IDLE);
    assign mem_req          = r_mem_req;
    assign mem_wr           = r_mem_wr;
    // Bytes walk upward from the effective address and wrap naturally.
    assign mem_addr         = r_addr + {{(ADDR_W-2){1'b0}}, r_k};
    assign mem_wdata        = r_data[{r_k, 3'b000} +: 8];
    // Broadcast is driven from the DONE state so a flush in that same cycle
    // can still suppress it.
    assign lsb_bc_valid     = (r_state == ST_DONE) && !roll_back;
    assign lsb_bc_entry     = r_entry;
    assign lsb_bc_value     = w_ext;
    assign store_done       = r_store_done;
    assign store_done_entry = r_entry;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_raw        <= '0;
            r_entry      <= '0;
            r_k          <= '0;
            r_last       <= '0;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_store_done <= 1'b0;
        end else if (rdy_in) begin
            r_store_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (issue_valid && !roll_back) begin
                        r_funct3  <= issue_funct3;
                        r_addr    <= issue_base + issue_imm;
                        r_data    <= issue_data;
                        r_entry   <= issue_entry;
                        r_raw     <= '0;
                        r_k       <= '0;
                        r_last    <= last_byte_idx(issue_funct3);
                        r_mem_req <= !issue_is_store;
                        r_mem_wr  <= 1'b0;
                        r_state   <= issue_is_store ? ST_WAIT_COMMIT : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // A flush discards any byte acked on the same edge.
                    if (roll_back) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (mem_ack) begin
                        r_raw[{r_k, 3'b000} +: 8] <= mem_rdata;
                        if (w_last_ack) begin
                            r_mem_req <= 1'b0;
                            r_state   <= ST_DONE;
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_WAIT_COMMIT: begin
                    // Commit beats a simultaneous flush: the ROB only flushes
                    // instructions younger than the one it commits.
                    if (commit_store && commit_entry == r_entry) begin
                        r_k       <= '0;
                        r_mem_req <= 1'b1;
                        r_mem_wr  <= 1'b1;
                        r_state   <= ST_STORE;
                    end else if (roll_back) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STORE: begin
                    if (mem_ack) begin
                        if (w_last_ack) begin
                            r_mem_req    <= 1'b0;
                            r_mem_wr     <= 1'b0;
                            r_store_done <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsb_mem_exec.sv
module tb_lsb_mem_exec;
    localparam int EB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in;
    logic          issue_valid, issue_ready, issue_is_store;
    logic [2:0]    issue_funct3;
    logic [31:0]   issue_base, issue_data, issue_imm;
    logic [EB-1:0] issue_entry, commit_entry, lsb_bc_entry, store_done_entry;
    logic          roll_back, commit_store;
    logic          mem_req, mem_wr, mem_ack;
    logic [31:0]   mem_addr, lsb_bc_value;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          lsb_bc_valid, store_done;

    logic [7:0]    mem [0:255];
    logic [31:0]   rd_q[$];
    logic [31:0]   wa_q[$];
    logic [7:0]    wd_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    lsb_mem_exec #(.ADDR_W(32), .ENTRY_BITS(EB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_is_store(issue_is_store), .issue_funct3(issue_funct3),
        .issue_base(issue_base), .issue_data(issue_data), .issue_imm(issue_imm),
        .issue_entry(issue_entry), .roll_back(roll_back),
        .commit_store(commit_store), .commit_entry(commit_entry),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .lsb_bc_valid(lsb_bc_valid), .lsb_bc_entry(lsb_bc_entry),
        .lsb_bc_value(lsb_bc_value), .store_done(store_done),
        .store_done_entry(store_done_entry)
    );

    always #5 clk_in = ~clk_in;

    // Memory controller model: acks each byte one cycle after the request,
    // paused by rdy_in and reset with the block.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk_in) begin
        if (rst_in) begin
            mem_ack <= 1'b0;
        end else if (rdy_in) begin
            if (mem_req && mem_ack) begin
                if (mem_wr) begin
                    mem[mem_addr[7:0]] <= mem_wdata;
                    wa_q.push_back(mem_addr);
                    wd_q.push_back(mem_wdata);
                end else begin
                    rd_q.push_back(mem_addr);
                end
            end
            mem_ack <= mem_req && !mem_ack;
        end
    end

    task automatic tick();
        @(posedge clk_in); #1;
    endtask

    task automatic clear_logs();
        rd_q.delete(); wa_q.delete(); wd_q.delete();
    endtask

    task automatic do_issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                            input logic [31:0] data, input logic [31:0] imm, input logic [EB-1:0] ent);
        int t;
        t = 0;
        while (!issue_ready && t < 50) begin tick(); t++; end
        n_vec++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL issue_ready: got %b want 1", issue_ready); end
        issue_valid = 1'b1; issue_is_store = st; issue_funct3 = f3;
        issue_base = base; issue_data = data; issue_imm = imm; issue_entry = ent;
        tick();
        issue_valid = 1'b0;
    endtask

    // Cycle numbering: the cycle in which issue_valid is high is cycle 1.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] base, input logic [31:0] imm,
                            input logic [EB-1:0] ent, input int stall_at,
                            output logic [31:0] val, output logic [EB-1:0] e, output int lat);
        int c;
        logic got;
        got = 1'b0; lat = 0; val = '0; e = '0;
        do_issue(1'b0, f3, base, 32'h0, imm, ent);
        c = 2;
        while (!got && c < 60) begin
            rdy_in = !(stall_at != 0 && c >= stall_at && c < stall_at + 3);
            @(negedge clk_in);
            if (lsb_bc_valid) begin got = 1'b1; val = lsb_bc_value; e = lsb_bc_entry; lat = c; end
            tick();
            c++;
        end
        rdy_in = 1'b1;
        n_vec++;
        if (!got) begin n_err++; $display("FAIL bc_timeout: no broadcast for entry %0d", ent); end
    endtask

    task automatic commit(input logic [EB-1:0] ent);
        commit_store = 1'b1; commit_entry = ent;
        tick();
        commit_store = 1'b0; commit_entry = '0;
    endtask

    task automatic wait_store_done(output logic got, output logic [EB-1:0] e);
        got = 1'b0; e = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_in);
            if (store_done) begin got = 1'b1; e = store_done_entry; end
            tick();
        end
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 40 && wa_q.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) tick();
        @(negedge clk_in);
        n_vec++;
        if ({issue_ready, mem_req, mem_wr, lsb_bc_valid, store_done} !== 5'b10000) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 10000",
                              {issue_ready, mem_req, mem_wr, lsb_bc_valid, store_done});
        end
        n_vec++;
        if ({mem_addr, mem_wdata, lsb_bc_value, lsb_bc_entry, store_done_entry} !== '0) begin
            n_err++; $display("FAIL reset_data: addr %h wdata %h val %h ent %h/%h want 0",
                              mem_addr, mem_wdata, lsb_bc_value, lsb_bc_entry, store_done_entry);
        end
        tick();
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        logic [31:0] v; logic [EB-1:0] e; int lat;
        clear_logs();
        run_load(3'b010, 32'h100, 32'hFFFF_FFFC, 4'd3, 0, v, e, lat);
        n_vec++;
        if (v !== 32'h1234_5678) begin n_err++; $display("FAIL lw_value: got %h want 12345678", v); end
        n_vec++;
        if (e !== 4'd3) begin n_err++; $display("FAIL lw_entry: got %0d want 3", e); end
        n_vec++;
        if (lat !== 10) begin n_err++; $display("FAIL lw_latency: got %0d want 10", lat); end
        n_vec++;
        if (rd_q.size() != 4 || rd_q[0] !== 32'hFC || rd_q[1] !== 32'hFD || rd_q[2] !== 32'hFE || rd_q[3] !== 32'hFF) begin
            n_err++; $display("FAIL lw_addr_seq: got %0d reads first %h want FC..FF",
                              rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'hx);
        end
    endtask

    task automatic test_extend();
        logic [31:0] v; logic [EB-1:0] e; int lat;
        run_load(3'b000, 32'h10, 32'h10, 4'd1, 0, v, e, lat);
        n_vec++;
        if (v !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_value: got %h want ffffff80", v); end
        n_vec++;
        if (lat !== 4) begin n_err++; $display("FAIL lb_latency: got %0d want 4", lat); end
        run_load(3'b100, 32'h20, 32'h0, 4'd2, 0, v, e, lat);
        n_vec++;
        if (v !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_value: got %h want 00000080", v); end
        run_load(3'b001, 32'h30, 32'h0, 4'd3, 0, v, e, lat);
        n_vec++;
        if (v !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_value: got %h want ffff8001", v); end
        run_load(3'b101, 32'h30, 32'h0, 4'd4, 0, v, e, lat);
        n_vec++;
        if (v !== 32'h0000_8001) begin n_err++; $display("FAIL lhu_value: got %h want 00008001", v); end
    endtask

    task automatic test_store_commit();
        logic got; logic [EB-1:0] e;
        clear_logs();
        do_issue(1'b1, 3'b001, 32'h40, 32'hAABB_CCDD, 32'h0, 4'd5);
        repeat (5) tick();
        n_vec++;
        if (wa_q.size() != 0 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL sh_precommit: got %0d writes req %b want 0 0", wa_q.size(), mem_req);
        end
        commit(4'd4);
        repeat (4) tick();
        n_vec++;
        if (wa_q.size() != 0) begin n_err++; $display("FAIL sh_wrong_tag: got %0d writes want 0", wa_q.size()); end
        commit(4'd5);
        wait_store_done(got, e);
        n_vec++;
        if (!got || e !== 4'd5) begin n_err++; $display("FAIL sh_done: got seen=%b entry %0d want 1 5", got, e); end
        n_vec++;
        if (wa_q.size() != 2 || wa_q[0] !== 32'h40 || wd_q[0] !== 8'hDD || wa_q[1] !== 32'h41 || wd_q[1] !== 8'hCC) begin
            n_err++; $display("FAIL sh_writes: got %0d writes want DD@40 CC@41", wa_q.size());
        end
    endtask

    task automatic test_rollback_load();
        logic seen;
        clear_logs();
        do_issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hFFFF_FFFC, 4'd2);
        for (int i = 0; i < 40 && rd_q.size() < 2; i++) tick();
        roll_back = 1'b1;
        tick();
        roll_back = 1'b0;
        @(negedge clk_in);
        n_vec++;
        if (mem_req !== 1'b0 || issue_ready !== 1'b1) begin
            n_err++; $display("FAIL rb_load_idle: got req %b ready %b want 0 1", mem_req, issue_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (lsb_bc_valid) seen = 1'b1;
        end
        tick();
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL rb_load_bc: got broadcast want none"); end
    endtask

    task automatic test_rollback_store();
        logic got; logic [EB-1:0] e;
        clear_logs();
        do_issue(1'b1, 3'b010, 32'h50, 32'h1122_3344, 32'h0, 4'd6);
        commit(4'd6);
        wait_writes(2);
        roll_back = 1'b1;
        tick();
        roll_back = 1'b0;
        wait_store_done(got, e);
        n_vec++;
        if (!got || e !== 4'd6) begin n_err++; $display("FAIL sw_rb_done: got seen=%b entry %0d want 1 6", got, e); end
        n_vec++;
        if (wa_q.size() != 4 || {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]} !== 32'h1122_3344) begin
            n_err++; $display("FAIL sw_rb_writes: got %0d writes mem %h want 4 11223344",
                              wa_q.size(), {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]});
        end
    endtask

    task automatic test_stall();
        logic [31:0] v; logic [EB-1:0] e; int lat;
        run_load(3'b010, 32'h100, 32'hFFFF_FFFC, 4'd7, 4, v, e, lat);
        n_vec++;
        if (v !== 32'h1234_5678 || e !== 4'd7) begin
            n_err++; $display("FAIL stall_value: got %h/%0d want 12345678/7", v, e);
        end
        n_vec++;
        if (lat !== 13) begin n_err++; $display("FAIL stall_latency: got %0d want 13", lat); end
    endtask

    task automatic test_reset_mid_store();
        clear_logs();
        do_issue(1'b1, 3'b010, 32'h60, 32'hDEAD_BEEF, 32'h0, 4'd9);
        commit(4'd9);
        wait_writes(1);
        rst_in = 1'b1;
        tick();
        @(negedge clk_in);
        n_vec++;
        if ({mem_req, mem_wr, lsb_bc_valid, store_done} !== 4'b0000 || issue_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_store_ctrl: got %b ready %b want 0000 1",
                              {mem_req, mem_wr, lsb_bc_valid, store_done}, issue_ready);
        end
        n_vec++;
        if ({mem_addr, mem_wdata, lsb_bc_value, lsb_bc_entry, store_done_entry} !== '0) begin
            n_err++; $display("FAIL rst_store_data: addr %h wdata %h val %h ent %h/%h want 0",
                              mem_addr, mem_wdata, lsb_bc_value, lsb_bc_entry, store_done_entry);
        end
        tick();
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] v; logic [EB-1:0] e; int lat;
        clear_logs();
        run_load(3'b000, 32'hFFFF_FFFF, 32'h1, 4'd4, 0, v, e, lat);
        n_vec++;
        if (rd_q.size() != 1 || rd_q[0] !== 32'h0) begin
            n_err++; $display("FAIL wrap_addr: got %0d reads first %h want 1 00000000",
                              rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'hx);
        end
        n_vec++;
        if (v !== 32'h0000_007F || e !== 4'd4) begin n_err++; $display("FAIL wrap_value: got %h/%0d want 7f/4", v, e); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'hFC] = 8'h78; mem[8'hFD] = 8'h56; mem[8'hFE] = 8'h34; mem[8'hFF] = 8'h12;
        mem[8'h20] = 8'h80;
        mem[8'h30] = 8'h01; mem[8'h31] = 8'h80;
        mem[8'h00] = 8'h7F;
        rst_in = 1'b1; rdy_in = 1'b1; issue_valid = 1'b0; issue_is_store = 1'b0;
        issue_funct3 = '0; issue_base = '0; issue_data = '0; issue_imm = '0; issue_entry = '0;
        roll_back = 1'b0; commit_store = 1'b0; commit_entry = '0;
        tick();
        test_reset();
        test_lw();
        test_extend();
        test_store_commit();
        test_rollback_load();
        test_rollback_store();
        test_stall();
        test_reset_mid_store();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
